// File: rtl/uart_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arb_pkg
//   Shared definitions for the uart_tx_arb arbiter slice: FSM state
//   encodings and the default byte width of the uart_txd data port.
//   No ports (package).
// ----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    // FSM encodings, kept as plain 2-bit constants so they match the legacy
    // defines that other blocks on this bus still use.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_tx_arb_rr_pick
//   Combinational round-robin picker. Scans req starting at ptr, wrapping
//   mod NUM_REQ, and selects the first set bit.
//   Ports:
//     req  in  NUM_REQ   request vector
//     ptr  in  IDX_W     highest-priority index for this pick
//     gnt  out NUM_REQ   one-hot winner (all zero when no request)
//     idx  out IDX_W     binary index of the winner
//     any  out 1         at least one request is set
// ----------------------------------------------------------------------------
module uart_tx_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] k;

    // Offsets are visited from farthest to nearest, so the nearest set bit
    // after ptr is the last one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        sum = '0;
        k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= N_L) sum = sum - N_L;
            k = sum[IDX_W-1:0];
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// ----------------------------------------------------------------------------
// uart_tx_arb
//   Round-robin sequencer sharing one uart_txd among NUM_REQ byte sources.
//   One byte is framed per grant: IDLE (pick + capture) -> LAUNCH (start
//   pulse) -> WAIT (until done or watchdog) -> IDLE. All outputs registered.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     i_req             per-source request, held with data until granted
//     i_req_data        source k byte at [k*DATA_W +: DATA_W]
//     o_gnt             one-hot, one-cycle capture pulse
//     o_tx_start        one-cycle start pulse to uart_txd
//     o_tx_data         byte to uart_txd, stable from grant through WAIT
//     i_tx_done         done pulse from uart_txd (honoured in WAIT only)
//     o_busy            high whenever the FSM is not IDLE
//     o_timeout         one-cycle pulse when the watchdog aborts a frame
// ----------------------------------------------------------------------------
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic                      o_tx_start,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state_q,   state_d;
    logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [WD_W-1:0]    wd_cnt_q,  wd_cnt_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic               start_q,   start_d;
    logic [DATA_W-1:0]  data_q,    data_d;
    logic               busy_q,    busy_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0]             pick_gnt;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_any;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_bytes;
    logic [IDX_W-1:0]               next_ptr;

    // Packed layout puts source k at [k*DATA_W +: DATA_W], same as the port.
    assign req_bytes = i_req_data;

    uart_tx_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req (i_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Priority moves to the source after the one just served, whether the
    // frame completed or was aborted.
    assign next_ptr = (win_idx_q == IDX_LAST) ? '0 : win_idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_idx_d = win_idx_q;
        wd_cnt_d  = wd_cnt_q;
        data_d    = data_q;
        gnt_d     = '0;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_d     = pick_gnt;
                    data_d    = req_bytes[pick_idx];
                    win_idx_d = pick_idx;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_d  = 1'b1;
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Saturating so a long-stuck transmitter cannot wrap the
                // count back below the abort threshold.
                if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (i_tx_done) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (wd_cnt_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    rr_ptr_d  = next_ptr;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
            wd_cnt_q  <= '0;
            gnt_q     <= '0;
            start_q   <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_idx_q <= win_idx_d;
            wd_cnt_q  <= wd_cnt_d;
            gnt_q     <= gnt_d;
            start_q   <= start_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_gnt      = gnt_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;

endmodule
